// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: result = ina - inb mod 2^WIDTH, DIGIT bits per clock, LSB digit first.
// Optional signed-overflow flag (port ovf) is built only when SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_subtractor: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT:0]     diff;
    logic               last_step;

`ifdef SUB_OVERFLOW_EN
    logic               amsb_q, amsb_d;
    logic               bmsb_q, bmsb_d;
    logic               ovf_q, ovf_d;
`endif

    // One digit of the ripple: the extra top bit of the widened difference is the borrow.
    always_comb begin
        diff = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    end

    assign last_step = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
`ifdef SUB_OVERFLOW_EN
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = ina;
                    b_d      = inb;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
`ifdef SUB_OVERFLOW_EN
                    amsb_d   = ina[WIDTH-1];
                    bmsb_d   = inb[WIDTH-1];
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // New digit enters at the MSB end so after N steps the LSB digit lands at bit 0.
                res_d    = WIDTH'({diff[DIGIT-1:0], res_q} >> DIGIT);
                a_d      = WIDTH'({{DIGIT{1'b0}}, a_q} >> DIGIT);
                b_d      = WIDTH'({{DIGIT{1'b0}}, b_q} >> DIGIT);
                borrow_d = diff[DIGIT];
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) begin
                    bout_d  = diff[DIGIT];
`ifdef SUB_OVERFLOW_EN
                    ovf_d   = (amsb_q != bmsb_q) && (diff[DIGIT-1] != amsb_q);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SUB_OVERFLOW_EN
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
`ifdef SUB_OVERFLOW_EN
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor (WIDTH=16, DIGIT=4).
// Define SUB_OVERFLOW_EN for both files to exercise the overflow flag.
module tb_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ina;
    logic [WIDTH-1:0] inb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             bout;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ina       (ina),
        .inb       (inb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .bout      (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [WIDTH-1:0] ref_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = d + (1 << WIDTH);
        return WIDTH'(d);
    endfunction

    function automatic logic ref_bout(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return int'(a) < int'(b);
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int sa, sb, d;
        sa = int'($signed(a));
        sb = int'($signed(b));
        d  = sa - sb;
        return (d > 32767) || (d < -32768);
    endfunction

    task automatic check_res(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        chk({tag, "_result"}, 32'(result), 32'(ref_res(a, b)));
        chk({tag, "_bout"}, 32'(bout), 32'(ref_bout(a, b)));
`ifdef SUB_OVERFLOW_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(a, b)));
`endif
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk("wait_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        ina      = a;
        inb      = b;
        tick();
        in_valid = 1'b0;
        ina      = 16'($urandom);
        inb      = 16'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_out_valid_low", 32'(out_valid), 32'd0);
        chk("hs_in_ready_high", 32'(in_ready), 32'd1);
    endtask

    task automatic full_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int lat;
        start_op(a, b);
        wait_result(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(N));
        check_res(tag, a, b);
        handshake();
    endtask

    initial begin
        logic [WIDTH-1:0] qa[$];
        logic [WIDTH-1:0] qb[$];
        logic [WIDTH-1:0] a, b, held_res;
        logic             held_bout;
        int               lat, got, last_cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ina       = '0;
        inb       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        tick();

        full_op("t1_1234_0234", 16'h1234, 16'h0234);
        chk("t1_result_const", 32'(ref_res(16'h1234, 16'h0234)), 32'h1000);
        full_op("t2_0000_0001", 16'h0000, 16'h0001);
        full_op("t2b_8000_0001", 16'h8000, 16'h0001);
        full_op("t2c_0005_0003", 16'h0005, 16'h0003);
        full_op("t2d_7fff_ffff", 16'h7FFF, 16'hFFFF);

        // Result held while the consumer stalls; new operands must not be taken.
        a = 16'hA5A5;
        b = 16'h5A5A;
        start_op(a, b);
        wait_result(lat);
        chk("t4_latency", 32'(lat), 32'(N));
        held_res  = result;
        held_bout = bout;
        in_valid  = 1'b1;
        ina       = 16'h1111;
        inb       = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_out_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
            chk("t4_hold_result", 32'(result), 32'(held_res));
            chk("t4_hold_bout", 32'(bout), 32'(held_bout));
        end
        check_res("t4", a, b);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_no_turnaround_in_ready", 32'(in_ready), 32'd1);
        chk("t4_no_turnaround_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("t4_idle_after", 32'(in_ready), 32'd1);

        // Asynchronous reset in the second RUN cycle abandons the operation.
        start_op(16'h1234, 16'h0001);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_result", 32'(result), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t5_rst_bout", 32'(bout), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        full_op("t5_ffff_ffff", 16'hFFFF, 16'hFFFF);

        // Streaming with both handshakes tied high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        got       = 0;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            if (out_valid) begin
                chk("t6_queue_nonempty", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) begin
                    a = qa.pop_front();
                    b = qb.pop_front();
                    check_res("t6", a, b);
                end
                if (last_cyc >= 0) chk("t6_interval", 32'(cyc - last_cyc), 32'(N + 2));
                last_cyc = cyc;
                got++;
            end
            if (in_ready) begin
                ina = 16'($urandom);
                inb = 16'($urandom);
                qa.push_back(ina);
                qb.push_back(inb);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_result_count", 32'(got), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
